// File: rtl/ether_pkg.sv
// Shared receive-path constants and the destination-address filter FSM encoding.
package ether_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StQuick,
      StScan,
      StDone
   } filt_state_e;

   localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;
   localparam int unsigned MAC_GROUP_BIT = 40;

   localparam logic [1:0] WSEL_HI  = 2'd0;
   localparam logic [1:0] WSEL_MID = 2'd1;
   localparam logic [1:0] WSEL_LO  = 2'd2;

endpackage

// File: rtl/mac_addr_filter_if.sv
// Receive-engine / host bundle for the destination-address filter.
interface mac_addr_filter_if #(
   parameter int unsigned IDX_W = 4
);
   logic             mac_rdy;
   logic [47:0]      mac_data;
   logic [1:0]       prmstp;
   logic             mcast;
   logic             tbl_we;
   logic [IDX_W-1:0] tbl_idx;
   logic [1:0]       tbl_wsel;
   logic [15:0]      tbl_data;
   logic             tbl_clr;
   logic             cmp_done;
   logic             cmp_res;
   logic [IDX_W-1:0] hit_idx;
   logic             busy;

   modport master (
      output mac_rdy, mac_data, prmstp, mcast,
      output tbl_we, tbl_idx, tbl_wsel, tbl_data, tbl_clr,
      input  cmp_done, cmp_res, hit_idx, busy
   );

   modport slave (
      input  mac_rdy, mac_data, prmstp, mcast,
      input  tbl_we, tbl_idx, tbl_wsel, tbl_data, tbl_clr,
      output cmp_done, cmp_res, hit_idx, busy
   );
endinterface

// File: rtl/mac_addr_table.sv
// Station/multicast address table: 16-bit word write port, valid bits, async read by index.
module mac_addr_table
   import ether_pkg::*;
#(
   parameter int unsigned N_ENTRIES = 14,
   parameter int unsigned IDX_W     = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [1:0]       wsel_i,
   input  logic [15:0]      wdata_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [47:0]      rd_data_o,
   output logic             rd_valid_o
);

   localparam logic [IDX_W:0] NumEntries = (IDX_W + 1)'(N_ENTRIES);

   logic [47:0]          mem_q [N_ENTRIES];
   logic [N_ENTRIES-1:0] valid_q;
   logic                 wr_en;

   assign wr_en = we_i && ({1'b0, idx_i} < NumEntries) && (wsel_i != 2'd3);

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         case (wsel_i)
            WSEL_HI:  mem_q[idx_i][47:32] <= wdata_i;
            WSEL_MID: mem_q[idx_i][31:16] <= wdata_i;
            default:  mem_q[idx_i][15:0]  <= wdata_i;
         endcase
      end
   end

   // Only the low word validates an entry, so a partially rewritten entry never matches.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (clr_i) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[idx_i] <= (wsel_i == WSEL_LO);
      end
   end

   assign rd_data_o  = mem_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/mac_addr_filter.sv
// Destination MAC filter: quick broadcast/multicast/promiscuous accept, then a table scan.
// Define MAC_ADDR_FILTER_STATS_EN to add saturating accept/reject counters.
module mac_addr_filter
   import ether_pkg::*;
#(
   parameter int unsigned N_ENTRIES = 14,
   parameter int unsigned IDX_W     = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   mac_addr_filter_if.slave  bus
`ifdef MAC_ADDR_FILTER_STATS_EN
   ,
   output logic [15:0]       acc_cnt_o,
   output logic [15:0]       rej_cnt_o
`endif
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_ENTRIES - 1);

   filt_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             acc_q, acc_d;
   logic [IDX_W-1:0] hit_q, hit_d;
   logic             done_q, done_d;
   logic             res_q, res_d;
   logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
   logic             busy_q, busy_d;
   logic             rdy_sync_q, rdy_prev_q;
   logic [47:0]      mac_q;
   logic [1:0]       prmstp_q;
   logic             mcast_q;
   logic             start;
   logic             quick_acc;
   logic [47:0]      rd_data;
   logic             rd_valid;

   mac_addr_table #(
      .N_ENTRIES (N_ENTRIES),
      .IDX_W     (IDX_W)
   ) u_table (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (bus.tbl_we),
      .idx_i      (bus.tbl_idx),
      .wsel_i     (bus.tbl_wsel),
      .wdata_i    (bus.tbl_data),
      .clr_i      (bus.tbl_clr),
      .rd_idx_i   (idx_q),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid)
   );

   // Rises seen outside IDLE are consumed here and never queued.
   assign start     = (state_q == StIdle) && rdy_sync_q && !rdy_prev_q;
   assign quick_acc = prmstp_q[0] || prmstp_q[1] || (mac_q == MAC_BCAST) ||
                      (mac_q[MAC_GROUP_BIT] && mcast_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         acc_q      <= 1'b0;
         hit_q      <= '1;
         done_q     <= 1'b0;
         res_q      <= 1'b0;
         hit_idx_q  <= '1;
         busy_q     <= 1'b0;
         rdy_sync_q <= 1'b0;
         rdy_prev_q <= 1'b0;
         mac_q      <= '0;
         prmstp_q   <= '0;
         mcast_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         hit_q      <= hit_d;
         done_q     <= done_d;
         res_q      <= res_d;
         hit_idx_q  <= hit_idx_d;
         busy_q     <= busy_d;
         rdy_sync_q <= bus.mac_rdy;
         rdy_prev_q <= rdy_sync_q;
         if (start) begin
            mac_q    <= bus.mac_data;
            prmstp_q <= bus.prmstp;
            mcast_q  <= bus.mcast;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      hit_d     = hit_q;
      done_d    = 1'b0;
      res_d     = res_q;
      hit_idx_d = hit_idx_q;
      busy_d    = busy_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StQuick;
               busy_d    = 1'b1;
               res_d     = 1'b0;
               hit_idx_d = '1;
               acc_d     = 1'b0;
               hit_d     = '1;
            end
         end
         StQuick: begin
            if (quick_acc) begin
               acc_d   = 1'b1;
               state_d = StDone;
            end else begin
               idx_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (rd_valid && (rd_data == mac_q)) begin
               acc_d   = 1'b1;
               hit_d   = idx_q;
               state_d = StDone;
            end else if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            res_d     = acc_q;
            hit_idx_d = hit_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.cmp_done = done_q;
   assign bus.cmp_res  = res_q;
   assign bus.hit_idx  = hit_idx_q;
   assign bus.busy     = busy_q;

`ifdef MAC_ADDR_FILTER_STATS_EN
   logic [15:0] acc_cnt_q, rej_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_cnt_q <= '0;
         rej_cnt_q <= '0;
      end else if (bus.tbl_clr) begin
         acc_cnt_q <= '0;
         rej_cnt_q <= '0;
      end else if (state_q == StDone) begin
         if (acc_q && (acc_cnt_q != 16'hFFFF)) acc_cnt_q <= acc_cnt_q + 16'd1;
         if (!acc_q && (rej_cnt_q != 16'hFFFF)) rej_cnt_q <= rej_cnt_q + 16'd1;
      end
   end

   assign acc_cnt_o = acc_cnt_q;
   assign rej_cnt_o = rej_cnt_q;
`endif

endmodule

// File: tb/tb_mac_addr_filter.sv
// Bench for mac_addr_filter: directed vector table, corner sequences and a randomized model run.
module tb_mac_addr_filter;

   localparam int N = 14;

   logic clk;
   logic rst;

   mac_addr_filter_if #(.IDX_W(4)) bus ();

`ifdef MAC_ADDR_FILTER_STATS_EN
   logic [15:0] acc_cnt;
   logic [15:0] rej_cnt;
`endif

   mac_addr_filter #(
      .N_ENTRIES (N),
      .IDX_W     (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef MAC_ADDR_FILTER_STATS_EN
      ,
      .acc_cnt_o (acc_cnt),
      .rej_cnt_o (rej_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model of the table contents and the statistics.
   logic [47:0] m_mac [16];
   bit          m_val [16];
   int          m_acc;
   int          m_rej;

   typedef struct {
      logic [47:0] mac;
      logic [1:0]  prm;
      bit          mc;
      bit          res;
      logic [3:0]  hit;
      int          lat;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 16; k++) m_val[k] = 0;
      m_acc = 0;
      m_rej = 0;
   endtask

   task automatic note_done(input bit res);
      if (res) m_acc = m_acc + 1;
      else m_rej = m_rej + 1;
   endtask

   task automatic tbl_op(input bit we, input logic [3:0] idx, input logic [1:0] wsel,
                         input logic [15:0] d, input bit clr);
      bus.tbl_we   = we;
      bus.tbl_idx  = idx;
      bus.tbl_wsel = wsel;
      bus.tbl_data = d;
      bus.tbl_clr  = clr;
      tick();
      bus.tbl_we  = 1'b0;
      bus.tbl_clr = 1'b0;
      if (clr) model_clear();
      if (we && int'(idx) < N && wsel != 2'd3) begin
         case (wsel)
            2'd0:    m_mac[idx][47:32] = d;
            2'd1:    m_mac[idx][31:16] = d;
            default: m_mac[idx][15:0]  = d;
         endcase
         if (!clr) m_val[idx] = (wsel == 2'd2);
      end
   endtask

   task automatic load_entry(input logic [3:0] idx, input logic [47:0] mac);
      tbl_op(1'b1, idx, 2'd0, mac[47:32], 1'b0);
      tbl_op(1'b1, idx, 2'd1, mac[31:16], 1'b0);
      tbl_op(1'b1, idx, 2'd2, mac[15:0], 1'b0);
   endtask

   function automatic void model_eval(input logic [47:0] mac, input logic [1:0] prm, input bit mc,
                                      output bit res, output logic [3:0] hit, output int lat);
      res = 0;
      hit = 4'hF;
      lat = 4 + N;
      if (prm != 2'b00 || mac == 48'hFFFF_FFFF_FFFF || (mac[40] && mc)) begin
         res = 1;
         lat = 4;
         return;
      end
      for (int k = 0; k < N; k++) begin
         if (m_val[k] && m_mac[k] == mac) begin
            res = 1;
            hit = 4'(k);
            lat = 5 + k;
            return;
         end
      end
   endfunction

   task automatic run_eval(input string name, input logic [47:0] mac, input logic [1:0] prm,
                           input bit mc, input bit exp_res, input logic [3:0] exp_hit,
                           input int exp_lat);
      int lat;
      bit seen;
      bus.mac_data = mac;
      bus.prmstp   = prm;
      bus.mcast    = mc;
      bus.mac_rdy  = 1'b1;
      lat  = 0;
      seen = 0;
      while (!seen && lat < 60) begin
         tick();
         lat++;
         if (bus.cmp_done) seen = 1;
      end
      check({name, " done_seen"}, 64'(seen), 64'd1);
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " res"}, 64'(bus.cmp_res), 64'(exp_res));
      check({name, " hit_idx"}, 64'(bus.hit_idx), 64'(exp_hit));
      if (seen) note_done(exp_res);
      tick();
      check({name, " done_one_cycle"}, 64'(bus.cmp_done), 64'd0);
      check({name, " busy_low"}, 64'(bus.busy), 64'd0);
      check({name, " res_held"}, 64'(bus.cmp_res), 64'(exp_res));
      bus.mac_rdy = 1'b0;
      tick();
      tick();
   endtask

   vec_t vecs [10];

   initial begin
      bit          r_res;
      logic [3:0]  r_hit;
      int          r_lat;
      logic [63:0] rnd;
      logic [47:0] mac;
      logic [1:0]  prm;
      bit          mc;
      int          ndone;

      for (int k = 0; k < 16; k++) m_mac[k] = '0;
      model_clear();
      rst          = 1'b1;
      bus.mac_rdy  = 1'b0;
      bus.mac_data = '0;
      bus.prmstp   = 2'b00;
      bus.mcast    = 1'b0;
      bus.tbl_we   = 1'b0;
      bus.tbl_idx  = '0;
      bus.tbl_wsel = '0;
      bus.tbl_data = '0;
      bus.tbl_clr  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("reset done", 64'(bus.cmp_done), 64'd0);
      check("reset res", 64'(bus.cmp_res), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset hit_idx", 64'(bus.hit_idx), 64'hF);

      // Quick accepts with an empty table.
      run_eval("bcast_empty", 48'hFFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b1, 4'hF, 4);
      run_eval("mcast_empty_rej", 48'h0100_5E00_0001, 2'b00, 1'b0, 1'b0, 4'hF, 4 + N);

      load_entry(4'd3, 48'h0800_2B11_2233);
      load_entry(4'd0, 48'h02AA_BBCC_DDEE);
      load_entry(4'd13, 48'h0A0B_0C0D_0E0F);

      vecs[0] = '{48'h0800_2B11_2233, 2'b00, 1'b0, 1'b1, 4'd3, 8};
      vecs[1] = '{48'h0800_2B11_2234, 2'b00, 1'b0, 1'b0, 4'hF, 18};
      vecs[2] = '{48'hFFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b1, 4'hF, 4};
      vecs[3] = '{48'h0100_5E00_0001, 2'b00, 1'b1, 1'b1, 4'hF, 4};
      vecs[4] = '{48'h0100_5E00_0001, 2'b00, 1'b0, 1'b0, 4'hF, 18};
      vecs[5] = '{48'h1234_5678_9ABC, 2'b10, 1'b0, 1'b1, 4'hF, 4};
      vecs[6] = '{48'h1234_5678_9ABC, 2'b01, 1'b0, 1'b1, 4'hF, 4};
      vecs[7] = '{48'h0800_2B11_2233, 2'b00, 1'b1, 1'b1, 4'd3, 8};
      vecs[8] = '{48'h02AA_BBCC_DDEE, 2'b00, 1'b0, 1'b1, 4'd0, 5};
      vecs[9] = '{48'h0A0B_0C0D_0E0F, 2'b00, 1'b0, 1'b1, 4'd13, 18};
      for (int i = 0; i < 10; i++) begin
         run_eval($sformatf("vec%0d", i), vecs[i].mac, vecs[i].prm, vecs[i].mc,
                  vecs[i].res, vecs[i].hit, vecs[i].lat);
      end

      // Partial rewrite invalidates an entry.
      load_entry(4'd5, 48'h0011_2233_4455);
      run_eval("entry5_hit", 48'h0011_2233_4455, 2'b00, 1'b0, 1'b1, 4'd5, 10);
      tbl_op(1'b1, 4'd5, 2'd0, 16'h0011, 1'b0);
      run_eval("entry5_partial", 48'h0011_2233_4455, 2'b00, 1'b0, 1'b0, 4'hF, 18);

      // Out-of-range index and word select 3 are ignored.
      tbl_op(1'b1, 4'd14, 2'd2, 16'h2233, 1'b0);
      tbl_op(1'b1, 4'd3, 2'd3, 16'hDEAD, 1'b0);
      run_eval("ignored_writes", 48'h0800_2B11_2233, 2'b00, 1'b0, 1'b1, 4'd3, 8);

      // Clear wins over a simultaneous validating write.
      tbl_op(1'b1, 4'd7, 2'd0, 16'h0A00, 1'b0);
      tbl_op(1'b1, 4'd7, 2'd1, 16'h0000, 1'b0);
      tbl_op(1'b1, 4'd7, 2'd2, 16'h0007, 1'b1);
      run_eval("clr_vs_we", 48'h0A00_0000_0007, 2'b00, 1'b0, 1'b0, 4'hF, 18);
      run_eval("clr_entry3", 48'h0800_2B11_2233, 2'b00, 1'b0, 1'b0, 4'hF, 18);

      // Second rise while busy yields exactly one done pulse; held-high does not retrigger.
      bus.mac_data = 48'h0800_2B11_2299;
      bus.prmstp   = 2'b00;
      bus.mcast    = 1'b0;
      bus.mac_rdy  = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 4) bus.mac_rdy = 1'b0;
         if (c == 7) bus.mac_rdy = 1'b1;
         tick();
         if (bus.cmp_done) ndone++;
      end
      check("busy_rise_pulses", 64'(ndone), 64'd1);
      note_done(1'b0);
      bus.mac_rdy = 1'b0;
      tick();
      tick();

      // Reset in the middle of a scan (entry 6 under compare).
      load_entry(4'd2, 48'h0000_0000_0002);
      bus.mac_data = 48'h0000_0000_0099;
      bus.mac_rdy  = 1'b1;
      repeat (9) tick();
      check("scan_busy", 64'(bus.busy), 64'd1);
      rst         = 1'b1;
      bus.mac_rdy = 1'b0;
      #1;
      check("midscan_rst busy", 64'(bus.busy), 64'd0);
      check("midscan_rst done", 64'(bus.cmp_done), 64'd0);
      check("midscan_rst hit_idx", 64'(bus.hit_idx), 64'hF);
      tick();
      rst = 1'b0;
      model_clear();
      ndone = 0;
      repeat (25) begin
         tick();
         if (bus.cmp_done) ndone++;
      end
      check("midscan_rst no_done", 64'(ndone), 64'd0);
      run_eval("after_rst_prm", 48'h0000_0000_0002, 2'b10, 1'b0, 1'b1, 4'hF, 4);
      run_eval("after_rst_tbl", 48'h0000_0000_0002, 2'b00, 1'b0, 1'b0, 4'hF, 18);

      // Randomized table traffic against the model.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            int idx;
            int nw;
            idx = $urandom_range(0, 15);
            rnd = {$urandom(), $urandom()};
            mac = rnd[47:0];
            if ($urandom_range(0, 1) == 0) mac[40] = 1'b0;
            nw = $urandom_range(1, 3);
            tbl_op(1'b1, 4'(idx), 2'd0, mac[47:32], 1'b0);
            if (nw > 1) tbl_op(1'b1, 4'(idx), 2'd1, mac[31:16], 1'b0);
            if (nw > 2) tbl_op(1'b1, 4'(idx), 2'd2, mac[15:0], 1'b0);
         end
         if ($urandom_range(0, 1) == 0) begin
            mac = m_mac[$urandom_range(0, N - 1)];
         end else begin
            rnd = {$urandom(), $urandom()};
            mac = rnd[47:0];
         end
         prm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         mc  = 1'($urandom_range(0, 1));
         model_eval(mac, prm, mc, r_res, r_hit, r_lat);
         run_eval($sformatf("rand%0d", it), mac, prm, mc, r_res, r_hit, r_lat);
      end

`ifdef MAC_ADDR_FILTER_STATS_EN
      check("stats acc", 64'(acc_cnt), 64'(m_acc));
      check("stats rej", 64'(rej_cnt), 64'(m_rej));
      tbl_op(1'b0, 4'd0, 2'd0, 16'h0, 1'b1);
      check("stats acc_clr", 64'(acc_cnt), 64'd0);
      check("stats rej_clr", 64'(rej_cnt), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mac_addr_filter.md
Name: mac_addr_filter

Overview:
- Destination-address filter for the Ethernet receive path, on the receive-buffer clock.
- Consumes the 48-bit destination MAC and its ready strobe produced by the receive engine.
- Returns the compare-done/compare-result pair the receive engine waits on before committing a frame.
- Matches against a host-loaded table of station/multicast addresses, plus broadcast, multicast-all, promiscuous and setup modes.

Parameters:
- N_ENTRIES, 14, number of address table entries (1..16).
- IDX_W, 4, width of the table index.

Ports:
- clk_i  in  1  receive-buffer clock.
- rst_i  in  1  asynchronous reset, active high.
- mac_rdy_i  in  1  destination MAC valid; a rising edge starts one evaluation.
- mac_data_i  in  48  destination MAC; [47:40] is the first byte on the wire; [40] is the group bit.
- prmstp_i  in  2  [1] = promiscuous/loop-accept, [0] = setup-frame mode.
- mcast_i  in  1  accept all multicast.
- tbl_we_i  in  1  table write strobe, one word per cycle.
- tbl_idx_i  in  IDX_W  entry index.
- tbl_wsel_i  in  2  word select: 0=[47:32], 1=[31:16], 2=[15:0]; 3 is ignored.
- tbl_data_i  in  16  write data.
- tbl_clr_i  in  1  clear all entry-valid bits.
- cmp_done_o  out  1  one-cycle pulse when the decision is ready.
- cmp_res_o  out  1  1 = accept; held from the done pulse until the next evaluation starts.
- hit_idx_o  out  IDX_W  matching entry index; all ones for a non-table accept or a reject.
- busy_o  out  1  evaluation in progress.

Behaviour:
- Reset: all outputs 0 except hit_idx_o = all ones. All valid bits cleared; FSM returns to IDLE. Reset may hit mid-scan: the evaluation is abandoned and no done pulse is issued.
- Input capture: mac_rdy_i is registered once. A start is the registered rise (rdy & ~rdy_q) seen in IDLE. mac_data_i and the mode inputs are latched at that start.
- FSM states: IDLE, QUICK, SCAN, DONE.
- IDLE -> QUICK on start. busy_o goes 1 and cmp_res_o is cleared.
- QUICK accepts, then goes to DONE, if any of:
  - prmstp_i[0] = 1;
  - prmstp_i[1] = 1;
  - the address is 48'hFFFF_FFFF_FFFF;
  - mac[40] = 1 and mcast_i = 1.
- QUICK otherwise -> SCAN with index k = 0.
- SCAN compares one entry per cycle. On entry k valid and equal: accept, hit_idx = k, go to DONE. After k = N_ENTRIES-1 with no hit: reject, go to DONE.
- DONE: cmp_done_o = 1 for exactly one cycle, busy_o drops, then IDLE.
- Latency from the mac_rdy_i rise to cmp_done_o:
  - quick accept: 4 cycles (sync, QUICK, DONE);
  - table hit at entry k: 5 + k cycles;
  - table miss: 4 + N_ENTRIES cycles.
- Table writes:
  - Each write stores one 16-bit word.
  - Writing wsel = 2 sets valid[idx]; writing wsel 0 or 1 clears valid[idx]. The host therefore writes words 0, 1, 2 in order.
  - idx >= N_ENTRIES is ignored.
  - Writes are accepted at all times, including during SCAN. Entry k is compared using its contents in the cycle it is scanned.
- tbl_clr_i together with tbl_we_i in the same cycle: the clear wins for valid bits; the data word is still stored.
- A new mac_rdy_i rise while busy is ignored and not queued. mac_rdy_i held high does not retrigger; it must fall and rise again.
- A zero address is never matched implicitly. Only valid entries match.

Optional Feature:
- Macro: MAC_ADDR_FILTER_STATS_EN.
- With the macro defined, two extra outputs exist: acc_cnt_o[15:0] and rej_cnt_o[15:0].
  - They count done pulses with cmp_res 1 and 0 respectively.
  - Counters saturate at 16'hFFFF.
  - Counters are cleared by rst_i and by tbl_clr_i.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package ether_pkg holds:
  - the FSM state encoding (IDLE/QUICK/SCAN/DONE);
  - constant MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  - constant MAC_GROUP_BIT = 40;
  - word-select encodings WSEL_HI/MID/LO.
- One natural sub-module, mac_addr_table: the N_ENTRIES x 48 storage, the valid bits, the 16-bit write port and an asynchronous read by scan index.

Test Plan:
- prmstp_i=2'b00, mcast_i=0, entry 3 = 08:00:2B:11:22:33 valid; mac 08002B112233 rises → cmp_done_o 8 cycles later, cmp_res_o=1, hit_idx_o=3.
- Same table, mac 08002B112234 → cmp_done_o after 18 cycles, cmp_res_o=0, hit_idx_o=4'hF.
- mac FFFFFFFFFFFF with an empty table → done after 4 cycles, accept. mac 01005E000001 with mcast_i=1 → accept; with mcast_i=0 and an empty table → reject.
- prmstp_i=2'b10 with any mac → accept in 4 cycles. Second mac_rdy_i rise while busy_o=1 → exactly one cmp_done_o pulse.
- Load entry 5, then write only wsel=0 to entry 5 → matching mac rejected. tbl_clr_i → previously valid entry 3 rejected.
- Assert rst_i during SCAN at k=6 → outputs reset immediately, no cmp_done_o. Next mac_rdy_i evaluates normally.
